sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares the single-port sprite/HUD pixel ROM between three fetch requesters: player 1 sprite, player 2 sprite and HUD/text overlay. Performs round-robin arbitration, issues at most one ROM read per cycle, and returns each read's data tagged with the requester ID after a fixed pipeline latency. Sits between the per-layer fetch units and the ROM macro, in the pixel clock domain feeding the color decider.

## Interface
Parameters:
- N_REQ, 3, number of requesters (index 0 = P1, 1 = P2, 2 = HUD)
- ADDR_W, 15, ROM address width
- DATA_W, 8, pixel width (RRRGGGBB)
- ROM_LAT, 2, ROM read latency in cycles from rom_rd to valid rom_data (≥1)

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous, active-low reset
- pause  in  1  when high, no new grants; in-flight reads still complete
- req  in  N_REQ  per-requester read request, held until granted
- req_addr  in  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
- rom_rd  out  1  registered ROM read strobe
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  1  response data valid
- rsp_id  out  2  requester index of current response
- rsp_data  out  DATA_W  response pixel, equals rom_data when rsp_valid

## Operation
- Round-robin pointer ptr (2 bits, 0..N_REQ-1); search order ptr, ptr+1, … wrapping mod N_REQ; first asserted req wins.
- gnt[i]=1 iff req[i] is the winner, pause=0, rst_n=1. At most one gnt bit high.
- On a grant to i: ptr ← (i+1) mod N_REQ; otherwise ptr unchanged (no grant → no rotation).
- Grant accepts the address: requester may drop req or present the next address in the following cycle; back-to-back grants to the same requester are allowed only if no other requester is asserting.
- Issue stage: rom_rd ← 1 and rom_addr ← req_addr[winner] on grant; rom_rd ← 0 otherwise, rom_addr holds last value.
- ID pipeline: shift register of (valid, id) with depth ROM_LAT, loaded from issue stage; output stage drives rsp_valid/rsp_id; rsp_data passes rom_data through.
- pause asserted mid-stream: grants stop that same cycle; already-issued reads emerge normally; ptr frozen.
- Requester with req high while others served is guaranteed a grant within N_REQ-1 grants (no starvation).

## Timing
- Reset values: ptr=0, rom_rd=0, rom_addr=0, pipeline valids=0, rsp_valid=0, rsp_id=0; gnt=0 while rst_n low.
- Latency: grant in cycle T → rom_rd=1 in T+1 → rsp_valid=1, rsp_id=i in T+1+ROM_LAT.
- Throughput: one response per cycle sustained; responses in grant order.
- Reset mid-operation: all in-flight entries dropped, no rsp_valid after reset deasserts until a new grant propagates.
- req with pause=1 and rst_n=1: gnt=0, req must be held.

## Structure
- Shared package (game_pkg): REQ_P1=0, REQ_P2=1, REQ_HUD=2, N_REQ, ROM address/data widths, pixel typedef.
- Sub-module rr_pick: combinational round-robin picker (req, ptr → one-hot gnt, winner index, any); arbiter holds ptr, issue register and ID pipeline.

## Test plan
- Reset then req=3'b111 held: gnts in order P1,P2,HUD,P1,…; rsp_id sequence 0,1,2,0 starting 3 cycles after first gnt (ROM_LAT=2).
- Single requester P2 req held, addresses 0x0100..0x0103 each cycle: gnt[1] every cycle, rom_addr 0x0100..0x0103 in T+1..T+4, four consecutive rsp_valid with id 1 and matching ROM model data.
- ptr=2, req=3'b011: P1 granted first (wrap), then P2; ptr ends at 2.
- pause raised one cycle after a grant with req=3'b111: no further gnt, exactly one rsp_valid emerges at T+3; lowering pause resumes from stored ptr.
- rst_n pulsed low while two reads in flight: rsp_valid stays 0, rom_rd=0, ptr=0 after release; first post-reset grant goes to lowest asserted index.
- Random req/pause for 10k cycles vs. scoreboard: one-hot gnt, in-order responses, no requester waits more than 2 grants.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the sprite/HUD pixel ROM arbiter.
package sprite_rom_arbiter_pkg;

  localparam int N_REQ       = 3;
  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 8;
  localparam int ROM_LAT_DEF = 2;
  localparam int ID_W        = 2;

  localparam logic [ID_W-1:0] REQ_P1  = 2'd0;
  localparam logic [ID_W-1:0] REQ_P2  = 2'd1;
  localparam logic [ID_W-1:0] REQ_HUD = 2'd2;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [ID_W-1:0]   req_id_t;

  // One slot of the response-tag pipeline.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

  function automatic req_id_t next_id(input req_id_t id);
    return (id == req_id_t'(N_REQ - 1)) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Fetch-side handshake and ROM-side bus of the sprite ROM arbiter.
interface sprite_rom_arbiter_if;
  import sprite_rom_arbiter_pkg::*;

  logic                    pause;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    rom_rd;
  rom_addr_t               rom_addr;
  pixel_t                  rom_data;
  logic                    rsp_valid;
  req_id_t                 rsp_id;
  pixel_t                  rsp_data;

  modport slave (
    input  pause, req, req_addr, rom_data,
    output gnt, rom_rd, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output pause, req, req_addr, rom_data,
    input  gnt, rom_rd, rom_addr, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module sprite_rom_arbiter_rr_pick
  import sprite_rom_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_id_t          ptr,
  output logic [N_REQ-1:0] gnt,
  output req_id_t          win,
  output logic             any
);

  // Walk the requesters in rotated order and latch the first hit.
  always_comb begin
    int      cand;
    req_id_t cand_id;
    logic    hit;
    any     = 1'b0;
    win     = 2'd0;
    gnt     = {N_REQ{1'b0}};
    cand    = 0;
    cand_id = 2'd0;
    hit     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand    = (int'(ptr) + k) % N_REQ;
      cand_id = req_id_t'(cand);
      hit     = ~any & req[cand_id];
      win     = hit ? cand_id : win;
      any     = any | hit;
    end
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = any & (win == req_id_t'(i));
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite/HUD pixel ROM between three fetch units,
// returning each read tagged with its requester after a fixed latency.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_rom_arbiter_if.slave  bus
);

  req_id_t          ptr_q, ptr_d;
  req_id_t          win_s;
  logic             any_s;
  logic             grant_s;
  logic [N_REQ-1:0] pick_gnt_s;

  logic             rom_rd_q, rom_rd_d;
  rom_addr_t        rom_addr_q, rom_addr_d;
  req_id_t          iss_id_q, iss_id_d;

  tag_t             pipe_q [ROM_LAT];
  tag_t             pipe_d [ROM_LAT];

  sprite_rom_arbiter_rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt_s),
    .win (win_s),
    .any (any_s)
  );

  // Grants are suppressed outright during pause and reset so requesters keep holding.
  assign grant_s = any_s & ~bus.pause & rst_n;
  assign bus.gnt = grant_s ? pick_gnt_s : {N_REQ{1'b0}};

  // Pointer rotation and issue-stage next state.
  always_comb begin
    ptr_d      = ptr_q;
    rom_rd_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    iss_id_d   = iss_id_q;
    if (grant_s) begin
      ptr_d      = next_id(win_s);
      rom_rd_d   = 1'b1;
      rom_addr_d = bus.req_addr[win_s*ADDR_W +: ADDR_W];
      iss_id_d   = win_s;
    end else begin
      ptr_d      = ptr_q;
      rom_rd_d   = 1'b0;
    end
  end

  // Tag pipeline mirrors the ROM latency so the id lines up with rom_data.
  always_comb begin
    pipe_d[0] = '{vld: rom_rd_q, id: iss_id_q};
    for (int k = 1; k < ROM_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 2'd0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= {ADDR_W{1'b0}};
      iss_id_q   <= 2'd0;
      for (int k = 0; k < ROM_LAT; k++) begin
        pipe_q[k] <= '{vld: 1'b0, id: 2'd0};
      end
    end else begin
      ptr_q      <= ptr_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      iss_id_q   <= iss_id_d;
      for (int k = 0; k < ROM_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign bus.rom_rd    = rom_rd_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = pipe_q[ROM_LAT-1].vld;
  assign bus.rsp_id    = pipe_q[ROM_LAT-1].id;
  assign bus.rsp_data  = bus.rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_sprite_rom_arbiter;
  import sprite_rom_arbiter_pkg::*;

  localparam int LAT = ROM_LAT_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sprite_rom_arbiter_if bus ();

  sprite_rom_arbiter #(.ROM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] rom_f(input logic [14:0] a);
    return a[7:0] ^ a[14:7] ^ 8'h5A;
  endfunction

  // ROM macro model: LAT-cycle read latency.
  logic [7:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_rd ? rom_f(bus.rom_addr) : 8'h00;
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign bus.rom_data = rom_pipe[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [14:0] addr;
  } pend_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mptr = 0;
  logic        exp_rd = 1'b0;
  logic [14:0] exp_addr = 15'd0;
  pend_t       q [$];
  int          wait_cnt [3];
  logic [2:0]  last_gnt = 3'b000;
  logic        last_rsp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [44:0] rnd_addrs();
    logic [44:0] a;
    a = {15'($urandom), 15'($urandom), 15'($urandom)};
    return a;
  endfunction

  // One pixel cycle: drive inputs, check against model, advance model.
  task automatic step(input logic [2:0] r, input logic p, input logic [44:0] a);
    int win;
    int best;
    int d;
    logic [2:0] eg;
    @(negedge clk);
    bus.req = r;
    bus.pause = p;
    bus.req_addr = a;
    cyc++;
    #1;
    chk("rom_rd", 32'(bus.rom_rd), 32'(exp_rd));
    chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(rom_f(q[0].addr)));
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    end
    win = -1;
    best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (!r[i]) wait_cnt[i] = 0;
      if (r[i]) begin
        d = (i - mptr + N_REQ) % N_REQ;
        if (d < best) begin
          best = d;
          win = i;
        end
      end
    end
    eg = (win >= 0 && !p) ? (3'b001 << win) : 3'b000;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    last_gnt = bus.gnt;
    last_rsp = bus.rsp_valid;
    exp_rd = 1'b0;
    if (eg != 3'b000) begin
      for (int i = 0; i < N_REQ; i++) if (i != win && r[i]) wait_cnt[i]++;
      chk("starve", 32'(wait_cnt[win] <= N_REQ - 1), 32'd1);
      wait_cnt[win] = 0;
      exp_rd = 1'b1;
      exp_addr = a[win*15 +: 15];
      q.push_back('{cyc + 1 + LAT, win, exp_addr});
      mptr = (win + 1) % N_REQ;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 3'b111;
    bus.pause = 1'b0;
    cyc++;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    bus.req = 3'b000;
    q.delete();
    mptr = 0;
    exp_rd = 1'b0;
    exp_addr = 15'd0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    #1;
    chk("rel_rom_rd", 32'(bus.rom_rd), 32'd0);
    chk("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0] r;
    logic       p;
    logic [2:0] g;
  } vec_t;

  vec_t        tv [12];
  int          cnt;
  logic        pend [3];
  logic [14:0] paddr [3];

  initial begin
    tv[0]  = '{3'b111, 1'b0, 3'b001};
    tv[1]  = '{3'b111, 1'b0, 3'b010};
    tv[2]  = '{3'b111, 1'b0, 3'b100};
    tv[3]  = '{3'b111, 1'b0, 3'b001};
    tv[4]  = '{3'b111, 1'b1, 3'b000};
    tv[5]  = '{3'b101, 1'b0, 3'b100};
    tv[6]  = '{3'b110, 1'b0, 3'b010};
    tv[7]  = '{3'b011, 1'b0, 3'b001};
    tv[8]  = '{3'b011, 1'b0, 3'b010};
    tv[9]  = '{3'b000, 1'b0, 3'b000};
    tv[10] = '{3'b010, 1'b0, 3'b010};
    tv[11] = '{3'b010, 1'b0, 3'b010};

    bus.req = 3'b000;
    bus.pause = 1'b0;
    bus.req_addr = 45'd0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    do_reset();

    // Directed rotation / wrap / pause vectors.
    for (int i = 0; i < 12; i++) begin
      step(tv[i].r, tv[i].p, rnd_addrs());
      chk("tbl_gnt", 32'(last_gnt), 32'(tv[i].g));
    end
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 45'd0);

    // Lone P2 streaming consecutive addresses.
    for (int k = 0; k < 4; k++) begin
      step(3'b010, 1'b0, {15'd0, 15'h0100 + 15'(k), 15'd0});
      chk("p2_stream_gnt", 32'(last_gnt), 32'h2);
    end
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 1'b0, 45'd0);
      if (last_rsp) cnt++;
    end
    chk("p2_stream_rsp_cnt", 32'(cnt), 32'd3);

    // Pause right after a grant: exactly one response drains, then resume.
    step(3'b111, 1'b0, rnd_addrs());
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b1, rnd_addrs());
      if (last_rsp) cnt++;
    end
    chk("pause_rsp_cnt", 32'(cnt), 32'd1);
    step(3'b111, 1'b0, rnd_addrs());
    for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 45'd0);

    // Reset with two reads in flight.
    step(3'b111, 1'b0, rnd_addrs());
    step(3'b111, 1'b0, rnd_addrs());
    do_reset();
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 45'd0);
    step(3'b110, 1'b0, rnd_addrs());
    chk("post_rst_gnt", 32'(last_gnt), 32'h2);
    for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 45'd0);

    // Randomized traffic; requests are held until granted.
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0;
      paddr[i] = 15'd0;
    end
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1'b1;
          paddr[i] = 15'($urandom);
        end
      end
      step({pend[2], pend[1], pend[0]}, $urandom_range(0, 99) < 15,
           {paddr[2], paddr[1], paddr[0]});
      for (int i = 0; i < N_REQ; i++) if (last_gnt[i]) pend[i] = 1'b0;
    end
    for (int i = 0; i < 6; i++) step(3'b000, 1'b0, 45'd0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
